pong_key_ctrl: RTL and testbench

Keyboard input controller for the pong game. It decodes the PS/2 scancode word from the `keyboard` unit into debounced per-player paddle commands and a one-cycle start strobe. It sits between `keyboard` and the `pong_top` FSMD / `pong_graph`, replacing the raw 16-bit scancode compares in the top-level FSM. It arbitrates simultaneous up/down presses per player and releases keys whose break code was lost.

---
 rtl/pong_key_ctrl.sv | 136 +++++++++++++
 tb/tb_pong_key_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pong_key_ctrl.sv
// Decodes the keyboard scancode word into debounced, arbitrated paddle commands
// plus start/any-make strobes for the pong game.
module pong_key_ctrl #(
  parameter logic [7:0] P1_UP_CODE   = 8'h75,
  parameter logic [7:0] P1_DN_CODE   = 8'h72,
  parameter logic [7:0] P2_UP_CODE   = 8'h1D,
  parameter logic [7:0] P2_DN_CODE   = 8'h1B,
  parameter logic [7:0] START_CODE   = 8'h29,
  parameter int         HOLD_TIMEOUT = 45
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] keycode,
  input  logic        frame_tick,
  input  logic        freeze,
  output logic        p1_up,
  output logic        p1_dn,
  output logic        p2_up,
  output logic        p2_dn,
  output logic        start_pulse,
  output logic        any_make
);

  localparam logic [7:0] AGE_LAST = 8'(HOLD_TIMEOUT - 1);

  logic [15:0] prev_code;
  logic        primed;
  logic        freeze_q;
  logic        make_q;
  logic        start_q;
  logic        p1_last_up;
  logic        p2_last_up;
  logic [3:0]  held;
  logic [7:0]  age [4];

  logic [7:0]  new_byte;
  logic        byte_valid;
  logic        is_make;
  logic        is_break;
  logic [3:0]  make_hit;
  logic [3:0]  break_hit;
  logic        unused_upper;

  assign unused_upper = ^keycode[31:16];
  assign new_byte     = keycode[7:0];

  // The first edge after reset only loads prev_code, so a word already present
  // on keycode while reset was held is not mistaken for a fresh keystroke.
  always_comb begin
    byte_valid = 1'b0;
    is_make    = 1'b0;
    is_break   = 1'b0;
    if (primed && (keycode[15:0] != prev_code) &&
        (new_byte != 8'h00) && (new_byte != 8'hE0) && (new_byte != 8'hF0)) begin
      byte_valid = 1'b1;
    end
    if (byte_valid) begin
      if (keycode[15:8] == 8'hF0) is_break = 1'b1;
      else                        is_make  = 1'b1;
    end
  end

  always_comb begin
    make_hit  = 4'b0000;
    break_hit = 4'b0000;
    make_hit[0]  = is_make  && (new_byte == P1_UP_CODE);
    make_hit[1]  = is_make  && (new_byte == P1_DN_CODE);
    make_hit[2]  = is_make  && (new_byte == P2_UP_CODE);
    make_hit[3]  = is_make  && (new_byte == P2_DN_CODE);
    break_hit[0] = is_break && (new_byte == P1_UP_CODE);
    break_hit[1] = is_break && (new_byte == P1_DN_CODE);
    break_hit[2] = is_break && (new_byte == P2_UP_CODE);
    break_hit[3] = is_break && (new_byte == P2_DN_CODE);
  end

  // A make outranks both a break and an expiring age count, so a typematic
  // repeat landing on the timeout tick keeps the key held with a fresh count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_code  <= 16'h0000;
      primed     <= 1'b0;
      freeze_q   <= 1'b0;
      make_q     <= 1'b0;
      start_q    <= 1'b0;
      p1_last_up <= 1'b0;
      p2_last_up <= 1'b0;
      held       <= 4'b0000;
      for (int i = 0; i < 4; i++) age[i] <= 8'h00;
    end else begin
      prev_code <= keycode[15:0];
      primed    <= 1'b1;
      freeze_q  <= freeze;
      make_q    <= is_make;
      start_q   <= is_make && (new_byte == START_CODE);
      for (int i = 0; i < 4; i++) begin
        if (make_hit[i]) begin
          held[i] <= 1'b1;
          age[i]  <= 8'h00;
        end else if (break_hit[i]) begin
          held[i] <= 1'b0;
          age[i]  <= 8'h00;
        end else if (frame_tick && held[i]) begin
          if (age[i] == AGE_LAST) begin
            held[i] <= 1'b0;
            age[i]  <= 8'h00;
          end else begin
            age[i] <= age[i] + 8'd1;
          end
        end
      end
      if (make_hit[0])      p1_last_up <= 1'b1;
      else if (make_hit[1]) p1_last_up <= 1'b0;
      if (make_hit[2])      p2_last_up <= 1'b1;
      else if (make_hit[3]) p2_last_up <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_up       <= 1'b0;
      p1_dn       <= 1'b0;
      p2_up       <= 1'b0;
      p2_dn       <= 1'b0;
      start_pulse <= 1'b0;
      any_make    <= 1'b0;
    end else begin
      p1_up       <= held[0] & (~held[1] |  p1_last_up) & ~freeze_q;
      p1_dn       <= held[1] & (~held[0] | ~p1_last_up) & ~freeze_q;
      p2_up       <= held[2] & (~held[3] |  p2_last_up) & ~freeze_q;
      p2_dn       <= held[3] & (~held[2] | ~p2_last_up) & ~freeze_q;
      start_pulse <= start_q;
      any_make    <= make_q;
    end
  end

endmodule

// File: tb/tb_pong_key_ctrl.sv
// Directed bench for pong_key_ctrl: each step queues the outputs it should
// produce, and the queue is checked two edges later.
module tb_pong_key_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] keycode;
  logic        frame_tick;
  logic        freeze;
  logic        p1_up, p1_dn, p2_up, p2_dn, start_pulse, any_make;
  logic [5:0]  obs;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign obs = {p1_up, p1_dn, p2_up, p2_dn, start_pulse, any_make};

  pong_key_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .keycode     (keycode),
    .frame_tick  (frame_tick),
    .freeze      (freeze),
    .p1_up       (p1_up),
    .p1_dn       (p1_dn),
    .p2_up       (p2_up),
    .p2_dn       (p2_dn),
    .start_pulse (start_pulse),
    .any_make    (any_make)
  );

  task automatic checkOutput(input int depth);
    exp_t e;
    if (sb_q.size() >= depth) begin
      e = sb_q.pop_front();
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("[TB] FAIL %s observed={p1u,p1d,p2u,p2d,st,any}=%b expected=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  // Inputs for step n are sampled at edge n; their effect is visible after edge n+1.
  task automatic applyStimulus(input logic [15:0] kc, input logic tick, input logic frz,
                               input logic [5:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    checkOutput(2);
    keycode    = {16'h0000, kc};
    frame_tick = tick;
    freeze     = frz;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  initial begin
    reset_n    = 1'b0;
    keycode    = 32'h0000_E075;
    frame_tick = 1'b0;
    freeze     = 1'b0;

    repeat (3) begin
      @(negedge clk);
      total++;
      assert (obs === 6'b000000) else begin
        bad++;
        $error("[TB] FAIL in_reset observed=%b expected=%b", obs, 6'b000000);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(16'hE075, 1'b0, 1'b0, 6'b000000, "post_reset");

    $display("[TB] player 1 press/release");
    applyStimulus(16'h00E0, 1'b0, 1'b0, 6'b000000, "p1_prefix");
    applyStimulus(16'hE075, 1'b0, 1'b0, 6'b100001, "p1_up_make");
    applyStimulus(16'hE075, 1'b0, 1'b0, 6'b100000, "p1_up_hold");
    applyStimulus(16'hE0F0, 1'b0, 1'b0, 6'b100000, "p1_break_prefix");
    applyStimulus(16'hF075, 1'b0, 1'b0, 6'b000000, "p1_up_break");
    applyStimulus(16'hF075, 1'b0, 1'b0, 6'b000000, "p1_idle");

    $display("[TB] player 2 arbitration");
    applyStimulus(16'h001D, 1'b0, 1'b0, 6'b001001, "p2_up_make");
    applyStimulus(16'h1D1B, 1'b0, 1'b0, 6'b000101, "p2_dn_wins");
    applyStimulus(16'h1D1B, 1'b0, 1'b0, 6'b000100, "p2_both_hold");
    applyStimulus(16'h1BF0, 1'b0, 1'b0, 6'b000100, "p2_break_prefix");
    applyStimulus(16'hF01B, 1'b0, 1'b0, 6'b001000, "p2_up_returns");
    applyStimulus(16'hF01B, 1'b0, 1'b0, 6'b001000, "p2_up_hold");
    applyStimulus(16'hF01D, 1'b0, 1'b0, 6'b000000, "p2_up_break");

    $display("[TB] hold timeout with repeat restart");
    applyStimulus(16'hE072, 1'b0, 1'b0, 6'b010001, "p1_dn_make");
    for (int i = 1; i <= 40; i++) applyStimulus(16'hE072, 1'b1, 1'b0, 6'b010000, "pre_repeat_tick");
    applyStimulus(16'h72E0, 1'b0, 1'b0, 6'b010000, "repeat_prefix");
    applyStimulus(16'hE072, 1'b0, 1'b0, 6'b010001, "repeat_make");
    for (int i = 1; i <= 45; i++)
      applyStimulus(16'hE072, 1'b1, 1'b0, (i < 45) ? 6'b010000 : 6'b000000, "timeout_tick");
    applyStimulus(16'hE072, 1'b0, 1'b0, 6'b000000, "released");

    $display("[TB] start strobe and freeze");
    applyStimulus(16'h0029, 1'b0, 1'b0, 6'b000011, "start_make");
    applyStimulus(16'h0029, 1'b0, 1'b0, 6'b000000, "start_one_cycle");
    applyStimulus(16'h29F0, 1'b0, 1'b0, 6'b000000, "start_break_prefix");
    applyStimulus(16'hF029, 1'b0, 1'b0, 6'b000000, "start_break");
    applyStimulus(16'h00E0, 1'b0, 1'b0, 6'b000000, "freeze_prefix");
    applyStimulus(16'hE075, 1'b0, 1'b1, 6'b000001, "frozen_make");
    applyStimulus(16'hE075, 1'b0, 1'b1, 6'b000000, "frozen_hold");
    applyStimulus(16'hE075, 1'b0, 1'b0, 6'b100000, "unfreeze");

    $display("[TB] repeat make on the timeout tick");
    for (int i = 1; i <= 44; i++) applyStimulus(16'hE075, 1'b1, 1'b0, 6'b100000, "conflict_pre_tick");
    applyStimulus(16'h75E0, 1'b0, 1'b0, 6'b100000, "conflict_prefix");
    applyStimulus(16'hE075, 1'b1, 1'b0, 6'b100001, "conflict_make_wins");
    for (int i = 1; i <= 45; i++)
      applyStimulus(16'hE075, 1'b1, 1'b0, (i < 45) ? 6'b100000 : 6'b000000, "conflict_recount");

    $display("[TB] unlisted codes and stray breaks");
    applyStimulus(16'h001C, 1'b0, 1'b0, 6'b000001, "unlisted_make");
    applyStimulus(16'hF072, 1'b0, 1'b0, 6'b000000, "break_not_held");
    applyStimulus(16'hE072, 1'b0, 1'b0, 6'b010001, "p1_dn_again");
    applyStimulus(16'h7275, 1'b0, 1'b0, 6'b100001, "p1_up_last_wins");
    applyStimulus(16'hF075, 1'b0, 1'b0, 6'b010000, "p1_dn_returns");
    applyStimulus(16'hF072, 1'b0, 1'b0, 6'b000000, "p1_all_released");

    while (sb_q.size() > 0) begin
      @(negedge clk);
      checkOutput(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
